e203_itcm_arbt_sched: RTL
=========================

# e203_itcm_arbt_sched

Two-requester scheduler that shares one ITCM SRAM ICB port between the LSU and the IFU. LSU has default priority; a starvation counter forces an IFU grant after a bounded number of consecutive LSU wins. A depth-2 owner FIFO supports back-to-back pipelined commands and routes each response to its issuer. It also maintains the IFU holdup flag. It sits between the core-side ICB masters and the ITCM SRAM controller.

## Interface
- AW, 16, ITCM byte-address width
- DW, 32, data width
- MW, 4, write-mask width (DW/8)
- STARVE_MAX, 4, consecutive LSU grants tolerated while IFU waits (1..15)

Ports:
- clk  input  1  clock; one clock domain.
- rst_n  input  1  reset; synchronous, active-low.
- lsu_icb_cmd_valid / _ready  input / output  1  LSU command handshake
- lsu_icb_cmd_read  input  1  1 = read
- lsu_icb_cmd_addr / _wdata / _wmask  input  AW / DW / MW  LSU command payload
- lsu_icb_rsp_valid / _ready  output / input  1  LSU response handshake
- lsu_icb_rsp_rdata / _err  output  DW / 1  LSU response payload
- ifu_icb_cmd_* / ifu_icb_rsp_*  same set as LSU, same directions and widths  IFU ports
- sram_icb_cmd_valid / _ready  output / input  1  downstream command handshake
- sram_icb_cmd_read / _addr / _wdata / _wmask  output  1 / AW / DW / MW  muxed payload
- sram_icb_rsp_valid / _ready  input / output  1  downstream response handshake
- sram_icb_rsp_rdata / _err  input  DW / 1  downstream response payload
- ifu_holdup  output  1  SRAM output still holds the last IFU fetch
- spurious_rsp  output  1  sticky: response arrived with no owner recorded
- sched_active  output  1  any cmd valid, or owner FIFO not empty

## Operation
- Grant is combinational.
  - prio_ifu = (starve_cnt == STARVE_MAX).
  - grant_lsu = lsu_valid & ~(prio_ifu & ifu_valid).
  - grant_ifu = ifu_valid & ~grant_lsu.
- can_issue = ~fifo_full.
  - sram_icb_cmd_valid = (lsu_valid | ifu_valid) & can_issue.
  - Payload is AND-OR muxed by grant; all-zero when no grant.
- Requester ready:
  - lsu_icb_cmd_ready = grant_lsu & can_issue & sram_icb_cmd_ready.
  - IFU is symmetric.
  - A non-granted requester sees ready = 0.
- Owner FIFO: depth 2, 1-bit entries, 1 = IFU.
  - Push on a downstream cmd handshake.
  - Pop on a downstream rsp handshake.
  - Push is blocked when full, even if a pop happens the same cycle.
  - Push and pop in the same cycle when not full or empty: occupancy unchanged.
- Response routing, with head = FIFO head entry:
  - lsu_icb_rsp_valid = sram_icb_rsp_valid & ~empty & ~head.
  - ifu_icb_rsp_valid = sram_icb_rsp_valid & ~empty & head.
  - sram_icb_rsp_ready = ~empty & (head ? ifu_rsp_ready : lsu_rsp_ready).
  - rdata and err are broadcast to both requesters.
- Empty FIFO with sram_icb_rsp_valid = 1:
  - sram_icb_rsp_ready = 0; no requester sees a response.
  - spurious_rsp is set and held until reset.
- starve_cnt is 4 bits.
  - Cleared on an IFU cmd handshake, or whenever ifu_valid = 0.
  - Incremented on an LSU cmd handshake while ifu_valid = 1; saturates at STARVE_MAX.
  - Otherwise held.
- ifu_holdup:
  - Set on an IFU cmd handshake.
  - Cleared on an LSU cmd handshake.
  - Otherwise held.

## Timing
- Reset (rst_n = 0 at a clk edge):
  - FIFO empty, starve_cnt = 0, ifu_holdup = 0, spurious_rsp = 0.
  - All rsp_valid outputs = 0.
  - sram_icb_rsp_ready = 0.
- Reset asserted mid-transaction: in-flight owners are discarded; the downstream controller is reset in the same cycle.
- Cmd path is 0-cycle combinational; no registered stage is added.
- Throughput: one command per cycle while the FIFO has space. At most 2 commands are outstanding; a third stalls until a pop.
- Response latency equals the downstream latency; the scheduler adds 0 cycles.
- Registered state updates at the clk edge after the handshake. ifu_holdup and starve_cnt are visible the next cycle.
- Requesters must hold valid and payload stable until ready. A granted requester is not preempted while it waits on sram_icb_cmd_ready, because prio_ifu can only change on a handshake or on an ifu_valid change.

## Test plan
- Reset check: after reset, all outputs are at their reset values. Single LSU read of addr 0x0010 -> sram cmd the same cycle; rsp 0xDEADBEEF is routed to the LSU only; ifu_holdup = 0.
- Contention: both requesters valid continuously, STARVE_MAX = 4, sram always ready -> grant pattern L,L,L,L,I repeating; starve_cnt returns to 0 after each I.
- Pipelining: 3 back-to-back LSU cmds with downstream rsp_ready held off -> 2 accepted, 3rd has ready = 0 until the first rsp pops; responses return in order.
- Interleaved owners: IFU cmd then LSU cmd on consecutive cycles -> 1st rsp reaches the IFU only, 2nd reaches the LSU only. ifu_holdup is 1 after the IFU cmd and 0 after the LSU cmd.
- Backpressure: IFU rsp_ready = 0 for 3 cycles -> sram_icb_rsp_ready = 0 for those cycles; no pop; LSU rsp_valid stays 0.
- Spurious response: sram_icb_rsp_valid pulsed with the FIFO empty -> spurious_rsp = 1 the next cycle and stays 1; it clears only on reset.

Source files
------------

// File: rtl/e203_itcm_arbt_sched.sv
// ---------------------------------------------------------------------------
// e203_itcm_arbt_sched
//
// Shares one ITCM SRAM ICB port between the LSU and the IFU.
//   - LSU wins by default. A starvation counter forces one IFU grant after
//     STARVE_MAX back-to-back LSU wins taken while the IFU was waiting.
//   - The command path is purely combinational (0 added cycles).
//   - A depth-2 owner FIFO (1 = IFU) records who issued each outstanding
//     command, so each response is steered back to its issuer.
//   - ifu_holdup tracks whether the SRAM output still holds the last IFU fetch.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   lsu_icb_cmd_*        LSU command channel (valid/ready/read/addr/wdata/wmask)
//   lsu_icb_rsp_*        LSU response channel (valid/ready/rdata/err)
//   ifu_icb_cmd_*        IFU command channel, same shape as the LSU one
//   ifu_icb_rsp_*        IFU response channel
//   sram_icb_cmd_*       muxed command toward the SRAM controller
//   sram_icb_rsp_*       response from the SRAM controller
//   ifu_holdup           SRAM output still holds the last IFU fetch
//   spurious_rsp         sticky: response seen with no recorded owner
//   sched_active         any command valid, or responses still outstanding
// ---------------------------------------------------------------------------
module e203_itcm_arbt_sched #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int MW         = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          lsu_icb_cmd_valid,
  output logic          lsu_icb_cmd_ready,
  input  logic          lsu_icb_cmd_read,
  input  logic [AW-1:0] lsu_icb_cmd_addr,
  input  logic [DW-1:0] lsu_icb_cmd_wdata,
  input  logic [MW-1:0] lsu_icb_cmd_wmask,
  output logic          lsu_icb_rsp_valid,
  input  logic          lsu_icb_rsp_ready,
  output logic [DW-1:0] lsu_icb_rsp_rdata,
  output logic          lsu_icb_rsp_err,

  input  logic          ifu_icb_cmd_valid,
  output logic          ifu_icb_cmd_ready,
  input  logic          ifu_icb_cmd_read,
  input  logic [AW-1:0] ifu_icb_cmd_addr,
  input  logic [DW-1:0] ifu_icb_cmd_wdata,
  input  logic [MW-1:0] ifu_icb_cmd_wmask,
  output logic          ifu_icb_rsp_valid,
  input  logic          ifu_icb_rsp_ready,
  output logic [DW-1:0] ifu_icb_rsp_rdata,
  output logic          ifu_icb_rsp_err,

  output logic          sram_icb_cmd_valid,
  input  logic          sram_icb_cmd_ready,
  output logic          sram_icb_cmd_read,
  output logic [AW-1:0] sram_icb_cmd_addr,
  output logic [DW-1:0] sram_icb_cmd_wdata,
  output logic [MW-1:0] sram_icb_cmd_wmask,
  input  logic          sram_icb_rsp_valid,
  output logic          sram_icb_rsp_ready,
  input  logic [DW-1:0] sram_icb_rsp_rdata,
  input  logic          sram_icb_rsp_err,

  output logic          ifu_holdup,
  output logic          spurious_rsp,
  output logic          sched_active
);

  // Flattened command payload: {read, addr, wdata, wmask}
  localparam int CW = 1 + AW + DW + MW;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [CW-1:0] lsu_cmd, ifu_cmd, sram_cmd;

  logic [3:0] starve_cnt;
  logic       prio_ifu, grant_lsu, grant_ifu, can_issue;
  logic       cmd_hs, lsu_hs, ifu_hs, rsp_hs;

  // owner FIFO
  logic [1:0] own_q;
  logic       wptr, rptr;
  logic [1:0] cnt;
  logic       fifo_full, fifo_empty, head, push, pop;

  // -------------------------------------------------------------------------
  // Grant / command mux
  // -------------------------------------------------------------------------
  assign lsu_cmd = {lsu_icb_cmd_read, lsu_icb_cmd_addr, lsu_icb_cmd_wdata, lsu_icb_cmd_wmask};
  assign ifu_cmd = {ifu_icb_cmd_read, ifu_icb_cmd_addr, ifu_icb_cmd_wdata, ifu_icb_cmd_wmask};

  assign prio_ifu  = (starve_cnt == STARVE_LIM);
  assign grant_lsu = lsu_icb_cmd_valid & ~(prio_ifu & ifu_icb_cmd_valid);
  assign grant_ifu = ifu_icb_cmd_valid & ~grant_lsu;
  assign can_issue = ~fifo_full;

  // AND-OR mux: payload is all-zero when nobody is granted
  assign sram_cmd = ({CW{grant_lsu}} & lsu_cmd) | ({CW{grant_ifu}} & ifu_cmd);
  assign {sram_icb_cmd_read, sram_icb_cmd_addr, sram_icb_cmd_wdata, sram_icb_cmd_wmask} = sram_cmd;

  assign sram_icb_cmd_valid = (lsu_icb_cmd_valid | ifu_icb_cmd_valid) & can_issue;
  assign lsu_icb_cmd_ready  = grant_lsu & can_issue & sram_icb_cmd_ready;
  assign ifu_icb_cmd_ready  = grant_ifu & can_issue & sram_icb_cmd_ready;

  assign cmd_hs = sram_icb_cmd_valid & sram_icb_cmd_ready;
  assign lsu_hs = lsu_icb_cmd_valid & lsu_icb_cmd_ready;
  assign ifu_hs = ifu_icb_cmd_valid & ifu_icb_cmd_ready;

  // -------------------------------------------------------------------------
  // Response routing
  // -------------------------------------------------------------------------
  assign fifo_full  = (cnt == 2'd2);
  assign fifo_empty = (cnt == 2'd0);
  assign head       = own_q[rptr];

  assign lsu_icb_rsp_valid  = sram_icb_rsp_valid & ~fifo_empty & ~head;
  assign ifu_icb_rsp_valid  = sram_icb_rsp_valid & ~fifo_empty &  head;
  assign sram_icb_rsp_ready = ~fifo_empty & (head ? ifu_icb_rsp_ready : lsu_icb_rsp_ready);

  assign lsu_icb_rsp_rdata = sram_icb_rsp_rdata;
  assign ifu_icb_rsp_rdata = sram_icb_rsp_rdata;
  assign lsu_icb_rsp_err   = sram_icb_rsp_err;
  assign ifu_icb_rsp_err   = sram_icb_rsp_err;

  assign rsp_hs = sram_icb_rsp_valid & sram_icb_rsp_ready;

  // cmd_hs already implies ~fifo_full, so a pop in the same cycle never
  // lets a push sneak into a full FIFO.
  assign push = cmd_hs;
  assign pop  = rsp_hs;

  // -------------------------------------------------------------------------
  // Owner FIFO
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      own_q <= '0;
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      cnt   <= 2'd0;
    end else begin
      if (push) begin
        own_q[wptr] <= grant_ifu;
        wptr        <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Starvation counter, holdup flag, spurious-response flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt   <= 4'd0;
      ifu_holdup   <= 1'b0;
      spurious_rsp <= 1'b0;
    end else begin
      // counts only LSU wins taken while the IFU was actually waiting
      if (!ifu_icb_cmd_valid || ifu_hs)
        starve_cnt <= 4'd0;
      else if (lsu_hs && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + 4'd1;

      if (ifu_hs)      ifu_holdup <= 1'b1;
      else if (lsu_hs) ifu_holdup <= 1'b0;

      if (sram_icb_rsp_valid && fifo_empty) spurious_rsp <= 1'b1;
    end
  end

  assign sched_active = lsu_icb_cmd_valid | ifu_icb_cmd_valid | ~fifo_empty;

endmodule
